// File: rtl/tcdm2axi_bridge.sv
// Bridges single-word TCDM requests (req/gnt/r_valid) onto single-beat AXI4 transactions.
// One transaction in flight; a cycle-count guard answers with an error if the AXI side stalls.
module tcdm2axi_bridge #(
  parameter int unsigned            AddrWidth     = 32,
  parameter int unsigned            AxiAddrWidth  = 64,
  parameter int unsigned            AxiDataWidth  = 64,
  parameter int unsigned            AxiIdWidth    = 4,
  parameter logic [AxiIdWidth-1:0]  AxiId         = '0,
  parameter int unsigned            TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tcdm_req_i,
  input  logic [AddrWidth-1:0]      tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [31:0]               tcdm_wdata_i,
  input  logic [3:0]                tcdm_be_i,
  output logic                      tcdm_gnt_o,
  output logic                      tcdm_r_valid_o,
  output logic [31:0]               tcdm_r_rdata_o,
  output logic                      tcdm_r_opc_o,
  output logic [AxiIdWidth-1:0]     axi_aw_id_o,
  output logic [AxiAddrWidth-1:0]   axi_aw_addr_o,
  output logic [7:0]                axi_aw_len_o,
  output logic [2:0]                axi_aw_size_o,
  output logic [1:0]                axi_aw_burst_o,
  output logic                      axi_aw_valid_o,
  input  logic                      axi_aw_ready_i,
  output logic [AxiDataWidth-1:0]   axi_w_data_o,
  output logic [AxiDataWidth/8-1:0] axi_w_strb_o,
  output logic                      axi_w_last_o,
  output logic                      axi_w_valid_o,
  input  logic                      axi_w_ready_i,
  input  logic [1:0]                axi_b_resp_i,
  input  logic                      axi_b_valid_i,
  output logic                      axi_b_ready_o,
  output logic [AxiIdWidth-1:0]     axi_ar_id_o,
  output logic [AxiAddrWidth-1:0]   axi_ar_addr_o,
  output logic [7:0]                axi_ar_len_o,
  output logic [2:0]                axi_ar_size_o,
  output logic [1:0]                axi_ar_burst_o,
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  input  logic [AxiDataWidth-1:0]   axi_r_data_i,
  input  logic [1:0]                axi_r_resp_i,
  input  logic                      axi_r_last_i,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  output logic                      busy_o
);

  localparam int unsigned StrbW    = AxiDataWidth / 8;
  localparam int unsigned NumLanes = AxiDataWidth / 32;
  localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int unsigned CntW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ_AR, WAIT_R, RESP} state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [LaneW-1:0] req_lane, lane_q;
  logic             aw_done, w_done, aw_hs, w_hs, axi_busy, to_hit;

  if (NumLanes > 1) begin : g_lanes
    assign req_lane = tcdm_add_i[LaneW+1:2];
  end else begin : g_one_lane
    assign req_lane = '0;
  end

  assign axi_aw_id_o    = AxiId;
  assign axi_aw_len_o   = 8'd0;
  assign axi_aw_size_o  = 3'd2;
  assign axi_aw_burst_o = 2'b01;
  assign axi_ar_id_o    = AxiId;
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_size_o  = 3'd2;
  assign axi_ar_burst_o = 2'b01;
  assign axi_w_last_o   = 1'b1;

  assign tcdm_gnt_o = tcdm_req_i & (state == IDLE) & ~rst_i;
  assign busy_o     = (state != IDLE);
  assign aw_hs      = axi_aw_valid_o & axi_aw_ready_i;
  assign w_hs       = axi_w_valid_o & axi_w_ready_i;
  assign axi_busy   = state inside {WRITE, WAIT_B, READ_AR, WAIT_R};
  assign to_hit     = (TimeoutCycles != 0) && (cnt == CntW'(TimeoutCycles - 1));

  // Only the error bit of the response and no burst info matter for single beats.
  logic unused_resp;
  assign unused_resp = ^{axi_b_resp_i[0], axi_r_resp_i[0], axi_r_last_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      lane_q         <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      axi_aw_addr_o  <= '0;
      axi_aw_valid_o <= 1'b0;
      axi_w_data_o   <= '0;
      axi_w_strb_o   <= '0;
      axi_w_valid_o  <= 1'b0;
      axi_b_ready_o  <= 1'b0;
      axi_ar_addr_o  <= '0;
      axi_ar_valid_o <= 1'b0;
      axi_r_ready_o  <= 1'b0;
      tcdm_r_valid_o <= 1'b0;
      tcdm_r_rdata_o <= '0;
      tcdm_r_opc_o   <= 1'b0;
    end else begin
      cnt <= axi_busy ? cnt + 1'b1 : '0;
      if (axi_busy && to_hit) begin
        // Abandon the AXI side entirely; a late reply is simply never accepted.
        axi_aw_valid_o <= 1'b0;
        axi_w_valid_o  <= 1'b0;
        axi_b_ready_o  <= 1'b0;
        axi_ar_valid_o <= 1'b0;
        axi_r_ready_o  <= 1'b0;
        tcdm_r_valid_o <= 1'b1;
        tcdm_r_rdata_o <= 32'hDEAD_BEEF;
        tcdm_r_opc_o   <= 1'b1;
        state          <= RESP;
      end else begin
        unique case (state)
          IDLE: if (tcdm_req_i) begin
            lane_q <= req_lane;
            if (tcdm_wen_i) begin
              axi_ar_addr_o  <= AxiAddrWidth'(tcdm_add_i);
              axi_ar_valid_o <= 1'b1;
              state          <= READ_AR;
            end else begin
              axi_aw_addr_o  <= AxiAddrWidth'(tcdm_add_i);
              axi_w_data_o   <= {NumLanes{tcdm_wdata_i}};
              axi_w_strb_o   <= StrbW'(tcdm_be_i) << (req_lane * 4);
              axi_aw_valid_o <= 1'b1;
              axi_w_valid_o  <= 1'b1;
              aw_done        <= 1'b0;
              w_done         <= 1'b0;
              state          <= WRITE;
            end
          end
          WRITE: begin
            if (aw_hs) begin
              axi_aw_valid_o <= 1'b0;
              aw_done        <= 1'b1;
            end
            if (w_hs) begin
              axi_w_valid_o <= 1'b0;
              w_done        <= 1'b1;
            end
            if ((aw_done | aw_hs) && (w_done | w_hs)) begin
              axi_b_ready_o <= 1'b1;
              state         <= WAIT_B;
            end
          end
          WAIT_B: if (axi_b_valid_i) begin
            axi_b_ready_o  <= 1'b0;
            tcdm_r_valid_o <= 1'b1;
            tcdm_r_rdata_o <= '0;
            tcdm_r_opc_o   <= axi_b_resp_i[1];
            state          <= RESP;
          end
          READ_AR: if (axi_ar_ready_i) begin
            axi_ar_valid_o <= 1'b0;
            axi_r_ready_o  <= 1'b1;
            state          <= WAIT_R;
          end
          WAIT_R: if (axi_r_valid_i) begin
            axi_r_ready_o  <= 1'b0;
            tcdm_r_valid_o <= 1'b1;
            tcdm_r_rdata_o <= axi_r_data_i[lane_q*32 +: 32];
            tcdm_r_opc_o   <= axi_r_resp_i[1];
            state          <= RESP;
          end
          RESP: begin
            tcdm_r_valid_o <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Randomized scoreboard bench for tcdm2axi_bridge (64-bit AXI bus, 16-cycle timeout).
// The driver pushes the model's expected TCDM response; a negedge monitor pops and compares.
module tb_tcdm2axi_bridge;
  localparam int DW = 64;
  localparam int TO = 16;

  logic clk_i = 1'b0, rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        tcdm_req_i = 0, tcdm_wen_i = 0;
  logic [31:0] tcdm_add_i = 0, tcdm_wdata_i = 0;
  logic [3:0]  tcdm_be_i = 0;
  logic        tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_opc_o;
  logic [31:0] tcdm_r_rdata_o;
  logic [3:0]  axi_aw_id_o, axi_ar_id_o;
  logic [63:0] axi_aw_addr_o, axi_ar_addr_o, axi_w_data_o;
  logic [7:0]  axi_aw_len_o, axi_ar_len_o, axi_w_strb_o;
  logic [2:0]  axi_aw_size_o, axi_ar_size_o;
  logic [1:0]  axi_aw_burst_o, axi_ar_burst_o;
  logic        axi_aw_valid_o, axi_w_last_o, axi_w_valid_o, axi_b_ready_o, axi_ar_valid_o, axi_r_ready_o, busy_o;
  logic        axi_aw_ready_i = 0, axi_w_ready_i = 0, axi_b_valid_i = 0, axi_ar_ready_i = 0;
  logic        axi_r_valid_i = 0, axi_r_last_i = 1;
  logic [1:0]  axi_b_resp_i = 0, axi_r_resp_i = 0;
  logic [63:0] axi_r_data_i = 0;

  tcdm2axi_bridge #(.AddrWidth(32), .AxiAddrWidth(64), .AxiDataWidth(DW), .AxiIdWidth(4),
                    .AxiId(4'h5), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_add_i(tcdm_add_i), .tcdm_wen_i(tcdm_wen_i),
    .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i), .tcdm_gnt_o(tcdm_gnt_o),
    .tcdm_r_valid_o(tcdm_r_valid_o), .tcdm_r_rdata_o(tcdm_r_rdata_o), .tcdm_r_opc_o(tcdm_r_opc_o),
    .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_valid_o(axi_aw_valid_o),
    .axi_aw_ready_i(axi_aw_ready_i), .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
    .axi_w_last_o(axi_w_last_o), .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
    .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_valid_o(axi_ar_valid_o),
    .axi_ar_ready_i(axi_ar_ready_i), .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
    .axi_r_last_i(axi_r_last_i), .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] add; logic wen; logic [31:0] wdata; logic [3:0] be;
    logic [63:0] rdat; logic [1:0] resp; int ad, wd, bd, rd; bit to;
  } txn_t;
  typedef logic [32:0] rsp_t;  // {opc, rdata}

  int   checks = 0, errors = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic prev_rv = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++; errors++;
    $display("FAIL %s bound expired t=%0t", nm, $time);
  endtask

  // Reference: which 32-bit half of the 64-bit bus the byte address falls in.
  function automatic int lane_of(input logic [31:0] a);
    return ((a % 8) >= 4) ? 1 : 0;
  endfunction

  function automatic rsp_t model_rsp(input txn_t t);
    logic err = (t.resp == 2'd2) || (t.resp == 2'd3);
    if (t.to)   return {1'b1, 32'hDEAD_BEEF};
    if (!t.wen) return {err, 32'h0};
    return {err, (lane_of(t.add) == 1) ? t.rdat[63:32] : t.rdat[31:0]};
  endfunction

  function automatic txn_t mk(input logic [31:0] add, input logic wen, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [63:0] rdat, input logic [1:0] resp,
                              input int ad, input int wd, input int bd, input int rd);
    txn_t t;
    t.add = add; t.wen = wen; t.wdata = wdata; t.be = be; t.rdat = rdat; t.resp = resp;
    t.ad = ad; t.wd = wd; t.bd = bd; t.rd = rd; t.to = 0;
    return t;
  endfunction

  always @(negedge clk_i) begin
    if (tcdm_r_valid_o) begin
      chk("r_valid_pulse", prev_rv, 1'b0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_r_valid got rdata=%0h opc=%0b want none", tcdm_r_rdata_o, tcdm_r_opc_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tcdm_rsp", {tcdm_r_opc_o, tcdm_r_rdata_o}, mon_e);
      end
    end
    prev_rv = tcdm_r_valid_o;
  end

  task automatic issue(input txn_t t);
    @(negedge clk_i);
    tcdm_req_i = 1; tcdm_add_i = t.add; tcdm_wen_i = t.wen; tcdm_wdata_i = t.wdata; tcdm_be_i = t.be;
    #1 chk("gnt", tcdm_gnt_o, 1'b1);
    @(posedge clk_i); #1;
    tcdm_req_i = 0;
  endtask

  // AXI slave for one transaction, with per-transaction ready/valid delays.
  task automatic slave(input txn_t t);
    int ad = t.ad, wd = t.wd, c = 0;
    bit ag = 0, wg = 0;
    logic [7:0] strb = 8'(t.be) << (4 * lane_of(t.add));
    if (!t.wen) begin
      while (!(ag && wg)) begin
        @(negedge clk_i);
        if (axi_aw_ready_i) ag = 1;
        if (axi_w_ready_i)  wg = 1;
        axi_aw_ready_i = 0; axi_w_ready_i = 0;
        if (!(ag && wg)) chk("b_ready_early", axi_b_ready_o, 1'b0);
        if (ag && !wg)   chk("aw_drop_w_hold", {axi_aw_valid_o, axi_w_valid_o}, 2'b01);
        if (!ag) begin
          chk("aw_valid_held", axi_aw_valid_o, 1'b1);
          if (ad == 0) begin
            axi_aw_ready_i = 1;
            chk("aw_addr", axi_aw_addr_o, {32'h0, t.add});
            chk("aw_fields", {axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o}, {4'h5, 8'h0, 3'd2, 2'b01});
          end else ad--;
        end
        if (!wg) begin
          chk("w_valid_held", axi_w_valid_o, 1'b1);
          if (wd == 0) begin
            axi_w_ready_i = 1;
            chk("w_data", axi_w_data_o, {t.wdata, t.wdata});
            chk("w_strb_last", {axi_w_strb_o, axi_w_last_o}, {strb, 1'b1});
          end else wd--;
        end
        if (++c > 50) begin fail("aw_w_handshake"); return; end
      end
      repeat (t.bd) @(negedge clk_i);
      axi_b_valid_i = 1; axi_b_resp_i = t.resp; c = 0;
      while (!axi_b_ready_o) begin
        @(negedge clk_i);
        if (++c > 50) begin fail("b_ready_wait"); axi_b_valid_i = 0; return; end
      end
      @(negedge clk_i);
      axi_b_valid_i = 0;
      chk("rsp_after_b", tcdm_r_valid_o, 1'b1);
    end else begin
      while (!ag) begin
        @(negedge clk_i);
        if (axi_ar_ready_i) ag = 1;
        axi_ar_ready_i = 0;
        if (!ag) begin
          chk("ar_valid_held", axi_ar_valid_o, 1'b1);
          if (ad == 0) begin
            axi_ar_ready_i = 1;
            chk("ar_addr", axi_ar_addr_o, {32'h0, t.add});
            chk("ar_fields", {axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o}, {4'h5, 8'h0, 3'd2, 2'b01});
          end else ad--;
        end
        if (++c > 50) begin fail("ar_handshake"); return; end
      end
      chk("r_ready", axi_r_ready_o, 1'b1);
      repeat (t.rd) @(negedge clk_i);
      axi_r_valid_i = 1; axi_r_data_i = t.rdat; axi_r_resp_i = t.resp;
      @(negedge clk_i);
      axi_r_valid_i = 0;
      chk("rsp_after_r", tcdm_r_valid_o, 1'b1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy_o) return;
      @(negedge clk_i);
    end
    fail("wait_idle");
  endtask

  task automatic run(input txn_t t);
    exp_q.push_back(model_rsp(t));
    issue(t);
    slave(t);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int k;
    repeat (3) @(negedge clk_i);
    chk("reset_ctl", {tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_opc_o, busy_o, axi_aw_valid_o, axi_w_valid_o,
                      axi_b_ready_o, axi_ar_valid_o, axi_r_ready_o}, 9'h0);
    chk("reset_data", {tcdm_r_rdata_o, axi_aw_addr_o, axi_ar_addr_o, axi_w_data_o, axi_w_strb_o}, '0);
    rst_i = 0;

    // Directed cases
    run(mk(32'h1000_0004, 0, 32'hA5A5_1234, 4'b0011, 64'h0, 2'd0, 0, 0, 0, 0));
    run(mk(32'h1000_0008, 1, 32'h0, 4'hF, 64'h1111_2222_3333_4444, 2'd0, 0, 0, 0, 1));
    run(mk(32'h1000_000C, 1, 32'h0, 4'hF, 64'h1111_2222_3333_4444, 2'd0, 2, 0, 0, 0));
    run(mk(32'h2000_0010, 0, 32'hCAFE_0001, 4'b1100, 64'h0, 2'd0, 0, 6, 1, 0));
    run(mk(32'h2000_0014, 0, 32'h0BAD_F00D, 4'b1111, 64'h0, 2'd2, 3, 0, 0, 0));
    run(mk(32'h3000_0008, 1, 32'h0, 4'hF, 64'h9999_8888_7777_6666, 2'd3, 1, 0, 0, 2));

    // AR never accepted: error response 17 cycles after the grant, AR withdrawn
    t = mk(32'h4000_0000, 1, 32'h0, 4'hF, 64'h0, 2'd0, 0, 0, 0, 0);
    t.to = 1;
    exp_q.push_back(model_rsp(t));
    issue(t);
    k = 0;
    do begin
      @(negedge clk_i); k++;
      if (k == TO) chk("ar_valid_before_to", axi_ar_valid_o, 1'b1);
    end while (!tcdm_r_valid_o && k < 40);
    chk("timeout_latency", k, TO + 1);
    chk("ar_valid_after_to", axi_ar_valid_o, 1'b0);
    wait_idle();
    chk("ar_valid_idle", {axi_ar_valid_o, axi_r_ready_o}, 2'b00);

    // Reset while waiting for R: no response, everything cleared
    t = mk(32'h5000_0004, 1, 32'h0, 4'hF, 64'h0, 2'd0, 0, 0, 0, 0);
    axi_ar_ready_i = 1;
    issue(t);
    k = 0;
    while (!axi_r_ready_o && k < 20) begin @(negedge clk_i); k++; end
    axi_ar_ready_i = 0;
    chk("in_wait_r", axi_r_ready_o, 1'b1);
    @(negedge clk_i); rst_i = 1;
    @(negedge clk_i);
    chk("rst_mid_ctl", {tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_opc_o, busy_o, axi_aw_valid_o, axi_w_valid_o,
                        axi_b_ready_o, axi_ar_valid_o, axi_r_ready_o}, 9'h0);
    chk("rst_mid_data", {tcdm_r_rdata_o, axi_aw_addr_o, axi_ar_addr_o, axi_w_data_o, axi_w_strb_o}, '0);
    rst_i = 0;
    run(mk(32'h5000_0000, 0, 32'h1234_5678, 4'b0101, 64'h0, 2'd0, 1, 1, 0, 0));

    // Random traffic, delays kept well inside the timeout window
    for (int i = 0; i < 40; i++) begin
      run(mk($urandom, 1'($urandom), $urandom, 4'($urandom), {$urandom, $urandom}, 2'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
